// File: rtl/watch_pkg.sv
// Shared widths, field limits, state encoding and edit_field codes for the watch set editor.
package watch_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int TIME_W = HOUR_W + MIN_W + SEC_W;

    localparam logic [HOUR_W-1:0] HOUR_MAX   = 5'd23;
    localparam logic [MIN_W-1:0]  MINSEC_MAX = 6'd59;

    typedef enum logic [2:0] {
        IDLE,
        HOUR,
        MIN,
        SEC,
        COMMIT
    } watch_state_t;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

endpackage

// File: rtl/watch_field_step.sv
// Combinational wrap-around up/down step of one time field, modulo (max+1).
module watch_field_step #(
    parameter int W = 6
) (
    input  logic [W-1:0] value,
    input  logic [W-1:0] max,
    input  logic         up,
    input  logic         down,
    output logic [W-1:0] next
);

    // Simultaneous up and down cancel out; out-of-range inputs fold back into range.
    always_comb begin
        next = value;
        if (up && !down) begin
            next = (value >= max) ? '0 : value + W'(1);
        end else if (down && !up) begin
            next = (value == '0 || value > max) ? max : value - W'(1);
        end
    end

endmodule

// File: rtl/watch_set_ctrl.sv
// Button-driven hour/min/sec editor that loads the watch counter via bin_watch/set_watch.
// Optional inactivity abandon: define WATCH_SET_TIMEOUT_EN.
module watch_set_ctrl #(
    parameter int TIMEOUT_S = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_1hz,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_cancel,
    input  logic [4:0]  cur_hour,
    input  logic [5:0]  cur_min,
    input  logic [5:0]  cur_sec,
    output logic [16:0] bin_watch,
    output logic        set_watch,
    output logic        edit_active,
    output logic [1:0]  edit_field,
    output logic        blink
);

    import watch_pkg::*;

    watch_state_t      r_state;
    logic [HOUR_W-1:0] r_hour;
    logic [MIN_W-1:0]  r_min;
    logic [SEC_W-1:0]  r_sec;
    logic              r_setWatch;
    logic              r_editActive;
    logic [1:0]        r_editField;
    logic              r_blink;

    logic              w_busy;
    logic              w_abort;
    logic              w_stepOk;
    logic              w_timeout;
    logic [HOUR_W-1:0] w_capHour;
    logic [MIN_W-1:0]  w_capMin;
    logic [SEC_W-1:0]  w_capSec;
    logic [HOUR_W-1:0] w_hourNext;
    logic [MIN_W-1:0]  w_minNext;
    logic [SEC_W-1:0]  w_secNext;

    assign w_busy   = (r_state == HOUR) || (r_state == MIN) || (r_state == SEC);
    assign w_abort  = btn_cancel || w_timeout;
    assign w_stepOk = w_busy && !w_abort && !btn_mode;

    assign w_capHour = (cur_hour > HOUR_MAX)   ? HOUR_MAX   : cur_hour;
    assign w_capMin  = (cur_min  > MINSEC_MAX) ? MINSEC_MAX : cur_min;
    assign w_capSec  = (cur_sec  > MINSEC_MAX) ? MINSEC_MAX : cur_sec;

`ifdef WATCH_SET_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_S + 1);

    logic [CNT_W-1:0] r_idleCnt;
    logic             w_anyBtn;

    assign w_anyBtn  = btn_mode || btn_up || btn_down || btn_cancel;
    assign w_timeout = w_busy && en_1hz && !w_anyBtn &&
                       (r_idleCnt == CNT_W'(TIMEOUT_S - 1));

    // Any button (including the mode press that enters HOUR) restarts the inactivity count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idleCnt <= '0;
        end else if (w_anyBtn) begin
            r_idleCnt <= '0;
        end else if (en_1hz && w_busy) begin
            r_idleCnt <= r_idleCnt + CNT_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    watch_field_step #(.W(HOUR_W)) u_hourStep (
        .value (r_hour),
        .max   (HOUR_MAX),
        .up    (w_stepOk && (r_state == HOUR) && btn_up),
        .down  (w_stepOk && (r_state == HOUR) && btn_down),
        .next  (w_hourNext)
    );

    watch_field_step #(.W(MIN_W)) u_minStep (
        .value (r_min),
        .max   (MINSEC_MAX),
        .up    (w_stepOk && (r_state == MIN) && btn_up),
        .down  (w_stepOk && (r_state == MIN) && btn_down),
        .next  (w_minNext)
    );

    watch_field_step #(.W(SEC_W)) u_secStep (
        .value (r_sec),
        .max   (MINSEC_MAX),
        .up    (w_stepOk && (r_state == SEC) && btn_up),
        .down  (w_stepOk && (r_state == SEC) && btn_down),
        .next  (w_secNext)
    );

    // Outputs are decoded from the next state so they line up with it in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_hour       <= '0;
            r_min        <= '0;
            r_sec        <= '0;
            r_setWatch   <= 1'b0;
            r_editActive <= 1'b0;
            r_editField  <= FIELD_NONE;
            r_blink      <= 1'b0;
        end else begin
            r_setWatch <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_blink <= 1'b0;
                    if (btn_mode) begin
                        r_state      <= HOUR;
                        r_hour       <= w_capHour;
                        r_min        <= w_capMin;
                        r_sec        <= w_capSec;
                        r_editActive <= 1'b1;
                        r_editField  <= FIELD_HOUR;
                        r_blink      <= 1'b1;
                    end
                end
                HOUR, MIN, SEC: begin
                    if (w_abort) begin
                        r_state      <= IDLE;
                        r_editActive <= 1'b0;
                        r_editField  <= FIELD_NONE;
                        r_blink      <= 1'b0;
                    end else if (btn_mode) begin
                        r_blink <= 1'b1;
                        case (r_state)
                            HOUR: begin
                                r_state     <= MIN;
                                r_editField <= FIELD_MIN;
                            end
                            MIN: begin
                                r_state     <= SEC;
                                r_editField <= FIELD_SEC;
                            end
                            default: begin
                                r_state      <= COMMIT;
                                r_setWatch   <= 1'b1;
                                r_editActive <= 1'b0;
                                r_editField  <= FIELD_NONE;
                                r_blink      <= 1'b0;
                            end
                        endcase
                    end else begin
                        r_hour <= w_hourNext;
                        r_min  <= w_minNext;
                        r_sec  <= w_secNext;
                        if (btn_up || btn_down) begin
                            r_blink <= 1'b1;
                        end else if (en_1hz) begin
                            r_blink <= !r_blink;
                        end
                    end
                end
                COMMIT: begin
                    r_state <= IDLE;
                    r_blink <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bin_watch   = {r_hour, r_min, r_sec};
    assign set_watch   = r_setWatch;
    assign edit_active = r_editActive;
    assign edit_field  = r_editField;
    assign blink       = r_blink;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed self-checking bench for watch_set_ctrl; build with WATCH_SET_TIMEOUT_EN to cover the timeout.
module tb_watch_set_ctrl;

    logic        clk;
    logic        rst;
    logic        en_1hz;
    logic        btn_mode;
    logic        btn_up;
    logic        btn_down;
    logic        btn_cancel;
    logic [4:0]  cur_hour;
    logic [5:0]  cur_min;
    logic [5:0]  cur_sec;
    logic [16:0] bin_watch;
    logic        set_watch;
    logic        edit_active;
    logic [1:0]  edit_field;
    logic        blink;

    int vectors;
    int miscompares;

    watch_set_ctrl #(.TIMEOUT_S(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .en_1hz      (en_1hz),
        .btn_mode    (btn_mode),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_cancel  (btn_cancel),
        .cur_hour    (cur_hour),
        .cur_min     (cur_min),
        .cur_sec     (cur_sec),
        .bin_watch   (bin_watch),
        .set_watch   (set_watch),
        .edit_active (edit_active),
        .edit_field  (edit_field),
        .blink       (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] pack(input int h, input int m, input int s);
        logic [4:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
        hh = h[4:0];
        mm = m[5:0];
        ss = s[5:0];
        return {hh, mm, ss};
    endfunction

    // Drive one cycle of inputs from a falling edge; returns on the next falling edge with inputs cleared.
    task automatic applyStimulus(input logic mode, input logic up, input logic down,
                                 input logic cancel, input logic tick);
        btn_mode   = mode;
        btn_up     = up;
        btn_down   = down;
        btn_cancel = cancel;
        en_1hz     = tick;
        @(negedge clk);
        btn_mode   = 1'b0;
        btn_up     = 1'b0;
        btn_down   = 1'b0;
        btn_cancel = 1'b0;
        en_1hz     = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic [16:0] expBin, input logic expSet,
                              input logic expActive, input logic [1:0] expField);
        checkOutput({tag, "_bin"}, 32'(bin_watch), 32'(expBin));
        checkOutput({tag, "_set"}, 32'(set_watch), 32'(expSet));
        checkOutput({tag, "_active"}, 32'(edit_active), 32'(expActive));
        checkOutput({tag, "_field"}, 32'(edit_field), 32'(expField));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        en_1hz      = 1'b0;
        btn_mode    = 1'b0;
        btn_up      = 1'b0;
        btn_down    = 1'b0;
        btn_cancel  = 1'b0;
        cur_hour    = 5'd13;
        cur_min     = 6'd45;
        cur_sec     = 6'd7;
        repeat (2) @(negedge clk);
        checkState("reset", pack(0, 0, 0), 1'b0, 1'b0, 2'd0);
        checkOutput("reset_blink", 32'(blink), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] idle buttons ignored");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkState("idle_ignore", pack(0, 0, 0), 1'b0, 1'b0, 2'd0);

        $display("[TB] full edit and commit");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkState("enter", pack(13, 45, 7), 1'b0, 1'b1, 2'd1);
        checkOutput("enter_blink", 32'(blink), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkState("hour_up2", pack(15, 45, 7), 1'b0, 1'b1, 2'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkState("min_down", pack(15, 44, 7), 1'b0, 1'b1, 2'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkState("sec_enter", pack(15, 44, 7), 1'b0, 1'b1, 2'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkState("commit", pack(15, 44, 7), 1'b1, 1'b0, 2'd0);
        checkOutput("commit_blink", 32'(blink), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkState("after_commit", pack(15, 44, 7), 1'b0, 1'b0, 2'd0);

        $display("[TB] wrap boundaries");
        cur_hour = 5'd23;
        cur_min  = 6'd59;
        cur_sec  = 6'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkState("hour_wrap_up", pack(0, 59, 0), 1'b0, 1'b1, 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkState("hour_wrap_dn", pack(23, 59, 0), 1'b0, 1'b1, 2'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkState("min_wrap_up", pack(23, 0, 0), 1'b0, 1'b1, 2'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkState("min_wrap_dn", pack(23, 59, 0), 1'b0, 1'b1, 2'd2);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkState("up_and_down", pack(23, 59, 0), 1'b0, 1'b1, 2'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkState("sec_wrap_dn", pack(23, 59, 59), 1'b0, 1'b1, 2'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkState("cancel_sec", pack(23, 59, 59), 1'b0, 1'b0, 2'd0);

        $display("[TB] cancel during hour edit");
        cur_hour = 5'd10;
        cur_min  = 6'd20;
        cur_sec  = 6'd30;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("cancel_noset", 32'(set_watch), 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkState("cancel", pack(13, 20, 30), 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkState("cancel_after", pack(13, 20, 30), 1'b0, 1'b0, 2'd0);

        $display("[TB] priority and blink");
        cur_hour = 5'd5;
        cur_min  = 6'd6;
        cur_sec  = 6'd7;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkState("mode_over_up", pack(5, 6, 7), 1'b0, 1'b1, 2'd2);
        checkOutput("blink_entry", 32'(blink), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("blink_tick", 32'(blink), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("blink_force", 32'(blink), 32'd1);
        checkOutput("min_up_tick", 32'(bin_watch), 32'(pack(5, 7, 7)));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("blink_tick2", 32'(blink), 32'd0);

        $display("[TB] reset during seconds edit");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("in_sec", 32'(edit_field), 32'd3);
        #2 rst = 1'b0;
        #1;
        checkState("mid_reset", pack(0, 0, 0), 1'b0, 1'b0, 2'd0);
        checkOutput("mid_reset_blink", 32'(blink), 32'd0);
        @(negedge clk);
        checkOutput("reset_noset", 32'(set_watch), 32'd0);
        rst = 1'b1;
        cur_hour = 5'd1;
        cur_min  = 6'd2;
        cur_sec  = 6'd3;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkState("recapture", pack(1, 2, 3), 1'b0, 1'b1, 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] clamp on capture");
        cur_hour = 5'd31;
        cur_min  = 6'd63;
        cur_sec  = 6'd60;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkState("clamp", pack(23, 59, 59), 1'b0, 1'b1, 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        cur_hour = 5'd2;
        cur_min  = 6'd3;
        cur_sec  = 6'd4;
`ifdef WATCH_SET_TIMEOUT_EN
        $display("[TB] inactivity timeout");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkState("to_two_ticks", pack(2, 3, 4), 1'b0, 1'b1, 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkState("to_expired", pack(2, 3, 4), 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("to_noset", 32'(set_watch), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkState("to_restart", pack(3, 3, 4), 1'b0, 1'b1, 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkState("to_restart_exp", pack(3, 3, 4), 1'b0, 1'b0, 2'd0);
`else
        $display("[TB] edit persists without timeout");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        checkState("persist", pack(2, 3, 4), 1'b0, 1'b1, 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
